data_ram_arbiter: RTL and testbench

Two-port arbiter and access sequencer in front of `data_ram`. It shares the single data RAM between port 0 (CPU MEM stage) and port 1 (debug/loader DMA). It issues one access at a time and holds address, mode and sign controls stable through the read-data cycle, because `data_ram` byte-selects and extends read data combinationally from the live `data_sram_addr[1:0]`, `data_sram_mode` and `data_sram_us`. It returns registered read data and done pulses to the requester that owns each access.

---
 rtl/data_ram_arbiter.sv | 172 +++++++++++++++++
 tb/tb_data_ram_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter: shares data_ram between the CPU MEM stage (port 0) and
// the debug/loader DMA (port 1), one access at a time.
module data_ram_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic [2:0]  p0_mode,
    input  logic [2:0]  p0_write_mode,
    input  logic        p0_us,
    input  logic        p0_lock,
    output logic        p0_gnt,
    output logic        p0_done,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic [2:0]  p1_mode,
    input  logic [2:0]  p1_write_mode,
    input  logic        p1_us,
    input  logic        p1_lock,
    output logic        p1_gnt,
    output logic        p1_done,
    output logic [31:0] p1_rdata,
    output logic        data_sram_en,
    output logic        data_sram_we,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    output logic [2:0]  data_sram_mode,
    output logic [2:0]  data_sram_write_mode,
    output logic        data_sram_us,
    input  logic [31:0] data_sram_rdata
);

    typedef enum logic [1:0] {IDLE, RDATA, RET} state_t;

    state_t      state_q, state_d;
    logic        last_gnt_q, last_gnt_d;
    logic [1:0]  lock_q, lock_d;
    logic [31:0] h_addr_q, h_addr_d;
    logic [2:0]  h_mode_q, h_mode_d;
    logic [2:0]  h_wmode_q, h_wmode_d;
    logic        h_us_q, h_us_d;
    logic        h_we_q, h_we_d;
    logic        h_port_q, h_port_d;
    logic        st_done_q, st_done_d;
    logic        st_port_q, st_port_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;

    logic        win, grant, ld_done;
    logic        w_we, w_us, w_lock;
    logic [31:0] w_addr, w_wdata;
    logic [2:0]  w_mode, w_wmode;

    // A held lock beats round-robin for exactly one arbitration.
    always_comb begin
        if (lock_q[0] && p0_req)      win = 1'b0;
        else if (lock_q[1] && p1_req) win = 1'b1;
        else if (p0_req && p1_req)    win = RR_EN ? ~last_gnt_q : 1'b0;
        else                          win = p1_req;
    end

    assign grant   = !rst && (state_q != RDATA) && (p0_req || p1_req);
    assign w_we    = win ? p1_we         : p0_we;
    assign w_us    = win ? p1_us         : p0_us;
    assign w_lock  = win ? p1_lock       : p0_lock;
    assign w_addr  = win ? p1_addr       : p0_addr;
    assign w_wdata = win ? p1_wdata      : p0_wdata;
    assign w_mode  = win ? p1_mode       : p0_mode;
    assign w_wmode = win ? p1_write_mode : p0_write_mode;

    assign p0_gnt  = grant && !win;
    assign p1_gnt  = grant && win;
    assign ld_done = (state_q == RET) && !h_we_q;
    assign p0_done = !rst && ((ld_done && !h_port_q) || (st_done_q && !st_port_q));
    assign p1_done = !rst && ((ld_done && h_port_q) || (st_done_q && st_port_q));
    assign p0_rdata = rdata0_q;
    assign p1_rdata = rdata1_q;

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        lock_d     = lock_q;
        h_addr_d   = h_addr_q;
        h_mode_d   = h_mode_q;
        h_wmode_d  = h_wmode_q;
        h_us_d     = h_us_q;
        h_we_d     = h_we_q;
        h_port_d   = h_port_q;
        st_done_d  = grant && w_we;
        st_port_d  = win;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        unique case (state_q)
            RDATA:   state_d = RET;
            default: state_d = (grant && !w_we) ? RDATA : IDLE;
        endcase
        if (grant) begin
            last_gnt_d = win;
            lock_d     = win ? {w_lock, 1'b0} : {1'b0, w_lock};
            h_addr_d   = w_addr;
            h_mode_d   = w_mode;
            h_wmode_d  = w_wmode;
            h_us_d     = w_us;
            h_we_d     = w_we;
            h_port_d   = win;
        end
        if (state_q == RDATA) begin
            if (h_port_q) rdata1_d = data_sram_rdata;
            else          rdata0_d = data_sram_rdata;
        end
    end

    // data_ram extends combinationally, so idle cycles keep the held controls.
    always_comb begin
        data_sram_en         = 1'b0;
        data_sram_we         = 1'b0;
        data_sram_addr       = h_addr_q;
        data_sram_wdata      = 32'h0;
        data_sram_mode       = h_mode_q;
        data_sram_write_mode = h_wmode_q;
        data_sram_us         = h_us_q;
        if (grant) begin
            data_sram_en         = 1'b1;
            data_sram_we         = w_we;
            data_sram_addr       = w_addr;
            data_sram_wdata      = w_wdata;
            data_sram_mode       = w_mode;
            data_sram_write_mode = w_wmode;
            data_sram_us         = w_us;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            lock_q     <= 2'b00;
            h_addr_q   <= 32'h0;
            h_mode_q   <= 3'h0;
            h_wmode_q  <= 3'h0;
            h_us_q     <= 1'b0;
            h_we_q     <= 1'b0;
            h_port_q   <= 1'b0;
            st_done_q  <= 1'b0;
            st_port_q  <= 1'b0;
            rdata0_q   <= 32'h0;
            rdata1_q   <= 32'h0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            lock_q     <= lock_d;
            h_addr_q   <= h_addr_d;
            h_mode_q   <= h_mode_d;
            h_wmode_q  <= h_wmode_d;
            h_us_q     <= h_us_d;
            h_we_q     <= h_we_d;
            h_port_q   <= h_port_d;
            st_done_q  <= st_done_d;
            st_port_q  <= st_port_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// tb_data_ram_arbiter: directed and random traffic against a transaction
// level model of the arbiter plus a small behavioural data_ram.
module tb_data_ram_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req, we, us, lock;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [2:0]  mode [2];
    logic [2:0]  wmode [2];

    logic        p0_gnt, p0_done, p1_gnt, p1_done;
    logic [31:0] p0_rdata, p1_rdata;
    logic        sram_en, sram_we, sram_us;
    logic [31:0] sram_addr, sram_wdata, ram_rdata;
    logic [2:0]  sram_mode, sram_wmode;

    logic        b_p0_gnt, b_p0_done, b_p1_gnt, b_p1_done;
    logic [31:0] b_p0_rdata, b_p1_rdata;
    logic        b_en, b_we, b_us;
    logic [31:0] b_addr, b_wdata;
    logic [2:0]  b_mode, b_wmode;

    data_ram_arbiter #(.RR_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .p0_req(req[0]), .p0_we(we[0]), .p0_addr(addr[0]),
        .p0_wdata(wdata[0]), .p0_mode(mode[0]), .p0_write_mode(wmode[0]),
        .p0_us(us[0]), .p0_lock(lock[0]),
        .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata),
        .p1_req(req[1]), .p1_we(we[1]), .p1_addr(addr[1]),
        .p1_wdata(wdata[1]), .p1_mode(mode[1]), .p1_write_mode(wmode[1]),
        .p1_us(us[1]), .p1_lock(lock[1]),
        .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
        .data_sram_en(sram_en), .data_sram_we(sram_we),
        .data_sram_addr(sram_addr), .data_sram_wdata(sram_wdata),
        .data_sram_mode(sram_mode), .data_sram_write_mode(sram_wmode),
        .data_sram_us(sram_us), .data_sram_rdata(ram_rdata)
    );

    data_ram_arbiter #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst(rst),
        .p0_req(req[0]), .p0_we(we[0]), .p0_addr(addr[0]),
        .p0_wdata(wdata[0]), .p0_mode(mode[0]), .p0_write_mode(wmode[0]),
        .p0_us(us[0]), .p0_lock(lock[0]),
        .p0_gnt(b_p0_gnt), .p0_done(b_p0_done), .p0_rdata(b_p0_rdata),
        .p1_req(req[1]), .p1_we(we[1]), .p1_addr(addr[1]),
        .p1_wdata(wdata[1]), .p1_mode(mode[1]), .p1_write_mode(wmode[1]),
        .p1_us(us[1]), .p1_lock(lock[1]),
        .p1_gnt(b_p1_gnt), .p1_done(b_p1_done), .p1_rdata(b_p1_rdata),
        .data_sram_en(b_en), .data_sram_we(b_we),
        .data_sram_addr(b_addr), .data_sram_wdata(b_wdata),
        .data_sram_mode(b_mode), .data_sram_write_mode(b_wmode),
        .data_sram_us(b_us), .data_sram_rdata(32'h0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // size codes: 0 byte, 1 half, 2 word; us = 1 means zero-extend
    function automatic logic [31:0] ld_ext(logic [31:0] w, logic [1:0] off,
                                           logic [2:0] md, logic u);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*off +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (md)
            3'd0:    return u ? {24'h0, b} : {{24{b[7]}}, b};
            3'd1:    return u ? {16'h0, h} : {{16{h[15]}}, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] st_merge(logic [31:0] old, logic [31:0] d,
                                             logic [1:0] off, logic [2:0] wm);
        logic [31:0] r;
        r = old;
        case (wm)
            3'd0:    r[8*off +: 8] = d[7:0];
            3'd1:    r[16*off[1] +: 16] = d[15:0];
            default: r = d;
        endcase
        return r;
    endfunction

    logic [31:0] mem [64];
    always @(posedge clk)
        if (sram_en && sram_we)
            mem[sram_addr[7:2]] <= st_merge(mem[sram_addr[7:2]], sram_wdata,
                                            sram_addr[1:0], sram_wmode);
    assign ram_rdata = ld_ext(mem[sram_addr[7:2]], sram_addr[1:0], sram_mode, sram_us);

    int          n_chk, n_pass, t;
    int          next_arb, rdata_cyc;
    int          done_at [2];
    bit          ld_pend [2];
    bit          last;
    bit [1:0]    lk, mgnt;
    logic [31:0] pend_rd [2];
    logic [31:0] rd_exp [2];
    logic [31:0] hold_addr;
    logic [31:0] mm [64];
    logic [1:0]  obs_gnt, obs_done, obs_gnt_b;
    logic        obs_en;
    logic [31:0] obs_rd [2];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, t);
    endtask

    task automatic model_reset();
        next_arb  = t + 1;
        rdata_cyc = -1;
        last      = 1'b1;
        lk        = 2'b00;
        for (int p = 0; p < 2; p++) begin
            done_at[p] = -1;
            ld_pend[p] = 1'b0;
            rd_exp[p]  = 32'h0;
        end
    endtask

    function automatic int pick();
        if (lk[0] && req[0]) return 0;
        if (lk[1] && req[1]) return 1;
        if (req == 2'b11)    return last ? 0 : 1;
        return req[1] ? 1 : 0;
    endfunction

    task automatic step();
        logic [1:0] eg, ed;
        int w;
        eg = 2'b00;
        ed = 2'b00;
        w  = 0;
        #1;
        obs_gnt   = {p1_gnt, p0_gnt};
        obs_done  = {p1_done, p0_done};
        obs_gnt_b = {b_p1_gnt, b_p0_gnt};
        obs_en    = sram_en;
        obs_rd[0] = p0_rdata;
        obs_rd[1] = p1_rdata;
        for (int p = 0; p < 2; p++)
            if (done_at[p] == t) begin
                ed[p] = ~rst;
                if (ld_pend[p]) rd_exp[p] = pend_rd[p];
            end
        if (!rst && t >= next_arb && req != 2'b00) begin
            w     = pick();
            eg[w] = 1'b1;
            lk    = 2'b00;
            lk[w] = lock[w];
            last  = (w == 1);
            if (we[w]) begin
                mm[addr[w][7:2]] = st_merge(mm[addr[w][7:2]], wdata[w],
                                            addr[w][1:0], wmode[w]);
                done_at[w] = t + 1;
                ld_pend[w] = 1'b0;
                next_arb   = t + 1;
            end else begin
                pend_rd[w] = ld_ext(mm[addr[w][7:2]], addr[w][1:0], mode[w], us[w]);
                done_at[w] = t + 2;
                ld_pend[w] = 1'b1;
                next_arb   = t + 2;
                rdata_cyc  = t + 1;
                hold_addr  = addr[w];
            end
        end
        check("gnt", obs_gnt, eg);
        check("done", obs_done, ed);
        check("p0_rdata", obs_rd[0], rd_exp[0]);
        check("p1_rdata", obs_rd[1], rd_exp[1]);
        check("sram_en", sram_en, |eg);
        check("sram_we", sram_we, (|eg) & we[w]);
        if (|eg) check("sram_addr", sram_addr, addr[w]);
        if ((|eg) && we[w]) check("sram_wdata", sram_wdata, wdata[w]);
        if (t == rdata_cyc) check("rdata_addr", sram_addr, hold_addr);
        if (rst) model_reset();
        mgnt = eg;
        t++;
    endtask

    task automatic tick();
        step();
        @(negedge clk);
    endtask

    task automatic set_req(int p, logic w, logic [31:0] a, logic [31:0] d,
                           logic [2:0] m, logic u, logic l);
        req[p]   = 1'b1;
        we[p]    = w;
        addr[p]  = a;
        wdata[p] = d;
        mode[p]  = m;
        wmode[p] = m;
        us[p]    = u;
        lock[p]  = l;
    endtask

    task automatic wait_gnt(int p);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!mgnt[p] && n < 20);
        check("gnt_wait", {31'h0, obs_gnt[p]}, 32'h1);
        req[p]  = 1'b0;
        lock[p] = 1'b0;
    endtask

    task automatic rand_req(int p);
        logic [2:0] sz;
        logic [1:0] off;
        sz  = 3'($urandom_range(0, 2));
        off = 2'($urandom_range(0, 3));
        if (sz == 3'd1) off[0] = 1'b0;
        else if (sz == 3'd2) off = 2'd0;
        set_req(p, 1'($urandom_range(0, 1)), {24'h0, 6'($urandom_range(0, 63)), off},
                $urandom, sz, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
    endtask

    initial begin
        n_chk = 0; n_pass = 0; t = 0;
        rst = 1'b1; req = 2'b00; we = 2'b00; us = 2'b00; lock = 2'b00;
        for (int p = 0; p < 2; p++) begin
            addr[p] = 32'h0; wdata[p] = 32'h0; mode[p] = 3'h0; wmode[p] = 3'h0;
        end
        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'h0;
            mm[i]  = 32'h0;
        end
        model_reset();
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_addr", sram_addr, 32'h0);
        check("rst_mode", {29'h0, sram_mode}, 32'h0);

        set_req(0, 1'b1, 32'h10, 32'hA5A5A5A5, 3'd2, 1'b0, 1'b0);
        wait_gnt(0);
        tick();
        check("st_done", obs_done, 2'b01);
        set_req(0, 1'b0, 32'h10, 32'h0, 3'd2, 1'b0, 1'b0);
        wait_gnt(0);
        tick();
        tick();
        check("ld_done", obs_done, 2'b01);
        check("ld_word", obs_rd[0], 32'hA5A5A5A5);

        set_req(0, 1'b1, 32'h20, 32'h000080FF, 3'd2, 1'b0, 1'b0);
        wait_gnt(0);
        set_req(1, 1'b0, 32'h21, 32'h0, 3'd0, 1'b0, 1'b0);
        wait_gnt(1);
        tick();
        tick();
        check("sb_done", obs_done, 2'b10);
        check("sb_data", obs_rd[1], 32'hFFFFFF80);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, 1'b1, 32'h30, 32'h11111111, 3'd2, 1'b0, 1'b0);
        set_req(1, 1'b1, 32'h34, 32'h22222222, 3'd2, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rr_order", obs_gnt, (i % 2 == 1) ? 2'b10 : 2'b01);
            check("fp_order", obs_gnt_b, 2'b01);
        end
        req = 2'b00;
        tick();
        tick();

        set_req(0, 1'b0, 32'h10, 32'h0, 3'd2, 1'b0, 1'b1);
        set_req(1, 1'b1, 32'h40, 32'h1234, 3'd2, 1'b0, 1'b0);
        tick();
        check("lk_first", obs_gnt, 2'b01);
        set_req(0, 1'b0, 32'h20, 32'h0, 3'd2, 1'b0, 1'b0);
        tick();
        check("lk_rdata", obs_gnt, 2'b00);
        tick();
        check("lk_ret", obs_gnt, 2'b01);
        set_req(0, 1'b0, 32'h24, 32'h0, 3'd2, 1'b0, 1'b0);
        tick();
        tick();
        check("lk_after", obs_gnt, 2'b10);
        req[1] = 1'b0;
        tick();
        req[0] = 1'b0;
        tick();
        tick();
        tick();

        set_req(0, 1'b0, 32'h10, 32'h0, 3'd2, 1'b0, 1'b0);
        tick();
        check("b2b_gnt", obs_gnt, 2'b01);
        set_req(0, 1'b1, 32'h44, 32'hDEADBEEF, 3'd2, 1'b0, 1'b0);
        tick();
        check("b2b_rdata_gnt", obs_gnt, 2'b00);
        tick();
        check("b2b_ld_done", obs_done, 2'b01);
        check("b2b_st_gnt", obs_gnt, 2'b01);
        check("b2b_data", obs_rd[0], 32'hA5A5A5A5);
        req[0] = 1'b0;
        tick();
        check("b2b_st_done", obs_done, 2'b01);
        tick();

        set_req(0, 1'b0, 32'h20, 32'h0, 3'd2, 1'b0, 1'b0);
        tick();
        req[0] = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("rr_done", obs_done, 2'b00);
        check("rr_en", {31'h0, obs_en}, 32'h0);
        check("rr_rdata", obs_rd[0], 32'h0);
        tick();
        check("rr_done2", obs_done, 2'b00);

        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 2; p++)
                if (!req[p] && $urandom_range(0, 1) == 1) rand_req(p);
            rst = ($urandom_range(0, 199) == 0);
            tick();
            for (int p = 0; p < 2; p++)
                if (mgnt[p]) begin
                    if ($urandom_range(0, 2) != 0) rand_req(p);
                    else begin
                        req[p]  = 1'b0;
                        lock[p] = 1'b0;
                    end
                end
        end
        req = 2'b00;
        rst = 1'b0;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
